// File: rtl/rd_fifo_arb_pkg.sv
// Shared state encoding and FIFO geometry helpers for the rd_fifo write-port arbiter.
package rd_fifo_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t CHECK = 2'd1;
    localparam state_t BURST = 2'd2;
    localparam state_t GAP   = 2'd3;

    localparam int WR_DEPTH_WIDTH_DFLT = 9;
    localparam int FIFO_DEPTH          = 1 << WR_DEPTH_WIDTH_DFLT;

    function automatic int fifo_depth(input int depth_width);
        return 1 << depth_width;
    endfunction

endpackage

// File: rtl/rd_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_rr_ptr, wrapping,
// found by rotating a doubled copy of the request vector.
module rd_fifo_wr_arbiter_rr_pick
    import rd_fifo_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W:0]     w_start;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    assign w_dbl   = {i_req, i_req};
    assign w_start = {1'b0, i_rr_ptr} + {{IDX_W{1'b0}}, 1'b1};

    // Rotate so bit 0 of w_rot is the requester just after the pointer
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = w_dbl[int'(w_start) + i];
        end
    end

    // Lowest set bit of the rotated vector is the winner's offset
    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end else begin
                w_off = w_off;
            end
        end
    end

    assign w_sum    = w_start + {1'b0, w_off};
    assign o_winner = IDX_W'((w_sum >= (IDX_W+1)'(N_REQ)) ? (w_sum - (IDX_W+1)'(N_REQ)) : w_sum);
    assign o_any    = |i_req;

endmodule

// File: rtl/rd_fifo_wr_arbiter.sv
// Shares the rd_fifo write port among N_REQ requesters: round-robin pick, reserve space
// from the write water level, then stream the whole burst without backpressure.
module rd_fifo_wr_arbiter
    import rd_fifo_arb_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int WR_DEPTH_WIDTH = 9,
    parameter  int LEN_W          = 8,
    parameter  int DATA_W         = 32,
    localparam int IDX_W          = $clog2(N_REQ)
) (
    input  logic                      i_wclk,
    input  logic                      i_wrst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*LEN_W-1:0]    i_req_len,
    input  logic [N_REQ-1:0]          i_src_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_src_data,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_src_ready,
    output logic                      o_fifo_w_en,
    output logic [DATA_W-1:0]         o_fifo_wdata,
    input  logic                      i_fifo_wfull,
    input  logic [WR_DEPTH_WIDTH:0]   i_fifo_wr_water_level,
    output logic                      o_burst_done,
    output logic                      o_busy,
    output logic                      o_ovf_err
);

    localparam int DEPTH  = fifo_depth(WR_DEPTH_WIDTH);
    localparam int FREE_W = WR_DEPTH_WIDTH + 2;
    localparam int CMP_W  = (FREE_W > LEN_W + 1) ? FREE_W : LEN_W + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [LEN_W:0]     r_len;
    logic [LEN_W:0]     r_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_ovf_err;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any;
    logic [LEN_W-1:0]   w_win_len;
    logic               w_sel_valid;
    logic [DATA_W-1:0]  w_sel_data;
    logic [FREE_W-1:0]  w_free;
    logic               w_fits;
    logic               w_beat;
    logic [LEN_W:0]     w_cnt_inc;
    logic               w_last;
    logic [N_REQ-1:0]   w_sel_onehot;

    rd_fifo_wr_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // AND-OR muxes for the winner's length and the granted source's beat
    always_comb begin
        w_win_len   = '0;
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_win_len   = w_win_len   | (i_req_len[i*LEN_W +: LEN_W]   & {LEN_W{w_winner == IDX_W'(i)}});
            w_sel_valid = w_sel_valid | (i_src_valid[i]                 & (r_sel == IDX_W'(i)));
            w_sel_data  = w_sel_data  | (i_src_data[i*DATA_W +: DATA_W] & {DATA_W{r_sel == IDX_W'(i)}});
        end
    end

    // Free space is widened so a full-depth reading cannot wrap
    assign w_free       = FREE_W'(DEPTH) - FREE_W'(i_fifo_wr_water_level);
    assign w_fits       = (CMP_W'(w_free) >= CMP_W'(r_len));
    assign w_beat       = w_sel_valid & ~i_fifo_wfull;
    assign w_cnt_inc    = r_cnt + (LEN_W+1)'(1);
    assign w_last       = (r_state == BURST) & w_beat & (w_cnt_inc == r_len);
    assign w_sel_onehot = N_REQ'(1) << r_sel;

    // State register
    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; CHECK never re-arbitrates so long bursts are not starved
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_any  ? CHECK : IDLE;
            CHECK:   w_state_nxt = w_fits ? BURST : CHECK;
            BURST:   w_state_nxt = w_last ? GAP   : BURST;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write-port outputs follow the granted source in the same cycle
    always_comb begin
        o_fifo_w_en  = 1'b0;
        o_fifo_wdata = '0;
        o_burst_done = 1'b0;
        case (r_state)
            BURST: begin
                o_fifo_w_en  = w_beat;
                o_fifo_wdata = w_beat ? w_sel_data : '0;
                o_burst_done = w_last;
            end
            default: begin
                o_fifo_w_en  = 1'b0;
                o_fifo_wdata = '0;
                o_burst_done = 1'b0;
            end
        endcase
    end

    // Selection latches, beat counter, grant and sticky overflow flag
    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            r_sel     <= '0;
            r_rr_ptr  <= IDX_W'(N_REQ - 1);
            r_len     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel <= w_winner;
                        r_len <= {1'b0, w_win_len} + (LEN_W+1)'(1);
                        r_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (w_fits) begin
                        r_gnt    <= w_sel_onehot;
                        r_rr_ptr <= r_sel;
                    end
                end
                BURST: begin
                    if (w_beat) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (w_last) begin
                        r_gnt <= '0;
                    end
                    if (i_fifo_wfull) begin
                        r_ovf_err <= 1'b1;
                    end
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_src_ready = r_gnt & {N_REQ{~i_fifo_wfull}};
    assign o_busy      = (r_state != IDLE);
    assign o_ovf_err   = r_ovf_err;

endmodule
